resp_router_bridge_buf: RTL and testbench
=========================================

Name: resp_router_bridge_buf

Overview:
- Parametrised response-side router for the XBAR bridge. It decodes the response ID into a per-master target and registers the response (valid, rdata, opc) in a one-entry slot per master.
- Adds valid/ready backpressure, binary or one-hot ID encoding, and detection, dropping and counting of illegal IDs.
- Sits between the bridge response path (TAS/slave side) and the per-master response network.

Parameters:
- N_MASTER, 20, number of masters (>=2).
- ID_MODE, 0, 0 = one-hot ID, 1 = binary ID.
- ID_WIDTH, 20, ID width. Must equal N_MASTER when ID_MODE=0 and $clog2(N_MASTER) when ID_MODE=1; elaboration error otherwise.
- DATA_WIDTH, 32, response data width.
- ERR_CNT_WIDTH, 8, width of the illegal-ID counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- data_r_valid_i  in  1  response valid from bridge
- data_r_ready_o  out  1  response accepted this cycle when high with valid
- data_ID_i  in  ID_WIDTH  response destination ID
- data_r_rdata_i  in  DATA_WIDTH  response data
- data_r_opc_i  in  1  response error/opcode bit
- data_r_valid_o  out  N_MASTER  per-master response valid
- data_r_ready_i  in  N_MASTER  per-master response ready
- data_r_rdata_o  out  N_MASTER*DATA_WIDTH  per-master data; master m occupies bits [m*DATA_WIDTH +: DATA_WIDTH]
- data_r_opc_o  out  N_MASTER  per-master opc
- err_clr_i  in  1  synchronous clear of err_cnt_o
- err_pulse_o  out  1  one-cycle pulse per dropped illegal response
- err_cnt_o  out  ERR_CNT_WIDTH  saturating count of illegal responses

Behaviour:
- Single clock: clk. Reset: rst, asynchronous, active-high.
- On reset, all outputs are 0: data_r_valid_o, data_r_rdata_o, data_r_opc_o, err_pulse_o, err_cnt_o. data_r_ready_o is combinational and is therefore 1 when the decoded slot is free.
- Decode (combinational):
  - ID_MODE=0: target = data_ID_i. Legal iff exactly one bit is set.
  - ID_MODE=1: target = 1 << data_ID_i. Legal iff data_ID_i < N_MASTER.
- Per-master slot m holds valid_q[m], rdata_q[m], opc_q[m], driven directly onto the outputs.
- A slot is free iff !valid_q[m] || data_r_ready_i[m]. Same-cycle drain and refill is allowed, giving full throughput.
- data_r_ready_o = illegal ? 1 : free[target]. It depends only on ID/valid and slot state, never on data.
- Legal accept (valid_i && ready_o): next cycle valid_q[target]=1 and rdata/opc are captured. Latency is exactly 1 cycle from accept to data_r_valid_o.
- Slot m drain (valid_q[m] && data_r_ready_i[m]) with no refill of m: valid_q[m] <= 0. rdata_q/opc_q hold their last value.
- Master handshake: once data_r_valid_o[m] is high, it and its data stay stable until data_r_ready_i[m] is sampled high.
- Illegal accept (always accepted, response dropped):
  - No slot changes.
  - err_pulse_o = 1 in the next cycle only.
  - err_cnt_o increments and saturates at all-ones.
- err_clr_i takes priority over a same-cycle increment: the counter becomes 0 and the pulse still fires.
- Slots are independent. Backpressure on master A never blocks a response to master B, provided B's slot is free.
- When data_r_valid_i=0, data_ID_i is don't-care and no state changes except drains.
- Reset mid-operation: all slots empty immediately (asynchronously) and pending responses are lost. The counter is 0.
- No combinational path from data_r_ready_i[m] to data_r_valid_o. The only combinational path is data_r_ready_i -> data_r_ready_o.

Test Plan:
- Reset/basic, ID_MODE=0, N_MASTER=4: ID=4'b0100, rdata=0xDEADBEEF, opc=0, ready_i=4'b1111 → next cycle data_r_valid_o=4'b0100 and master 2 rdata=0xDEADBEEF for 1 cycle; ready_o=1 throughout.
- Backpressure, ID_MODE=1, N_MASTER=4: ID=3 twice back-to-back, ready_i[3]=0 for 3 cycles.
  - Second response: ready_o=0 until ready_i[3]=1.
  - First rdata is held stable 3 cycles.
  - Then second delivered the cycle after the drain; no loss or duplication.
- Independence: slot 1 stalled (ready_i[1]=0, valid_q[1]=1), response to ID=0 → accepted immediately, delivered to master 0 next cycle.
- Illegal IDs:
  - ID_MODE=0 with ID=4'b0110, then ID=0 (with valid) → ready_o=1 both, no data_r_valid_o bits set, err_pulse_o high twice, err_cnt_o=2.
  - ID_MODE=1, N_MASTER=5, ID=7 → dropped, err_cnt_o+1.
- Saturation/clear, ERR_CNT_WIDTH=2: 5 illegal responses → err_cnt_o=3. Assert err_clr_i together with a 6th illegal → err_cnt_o=0, err_pulse_o=1.
- Reset mid-stream: stalled valid_q=4'b1010, assert rst asynchronously → data_r_valid_o=0 within the same cycle, err_cnt_o=0. After release, new accept to ID=1 delivers normally.

Source files
------------

// File: rtl/resp_router_bridge_buf.sv
// Response-side router for the XBAR bridge.
// Decodes the response ID into a per-master target and holds each response
// in a one-entry slot per master until that master accepts it. Responses with
// an illegal ID are accepted, dropped, flagged with a pulse and counted.
module resp_router_bridge_buf #(
    parameter int N_MASTER      = 20,
    parameter int ID_MODE       = 0,
    parameter int ID_WIDTH      = 20,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           data_r_valid_i,
    output logic                           data_r_ready_o,
    input  logic [ID_WIDTH-1:0]            data_ID_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    input  logic                           data_r_opc_i,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    input  logic [N_MASTER-1:0]            data_r_ready_i,
    output logic [N_MASTER*DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [N_MASTER-1:0]            data_r_opc_o,
    input  logic                           err_clr_i,
    output logic                           err_pulse_o,
    output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o
);

    // Reject parameter combinations where the ID width does not fit the encoding.
    if ((N_MASTER < 2) ||
        (ID_MODE != 0 && ID_MODE != 1) ||
        (ID_MODE == 0 && ID_WIDTH != N_MASTER) ||
        (ID_MODE == 1 && ID_WIDTH != $clog2(N_MASTER))) begin : g_param_check
        $error("resp_router_bridge_buf: inconsistent N_MASTER/ID_MODE/ID_WIDTH");
    end

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_CNT_WIDTH'(1);
    endfunction

    logic [N_MASTER-1:0]            target;
    logic                           legal;
    logic [N_MASTER-1:0]            free;
    logic                           accept;
    logic [N_MASTER-1:0]            fill;
    logic                           drop;

    logic [N_MASTER-1:0]            slot_vld_p1;
    logic [N_MASTER*DATA_WIDTH-1:0] slot_rdata_p1;
    logic [N_MASTER-1:0]            slot_opc_p1;
    logic                           err_pulse_p1;
    logic [ERR_CNT_WIDTH-1:0]       err_cnt_p1;

    // ---- stage p0: ID decode and slot-availability handshake (combinational)
    if (ID_MODE == 0) begin : g_onehot
        assign target = N_MASTER'(data_ID_i);
        assign legal  = (data_ID_i != '0) &&
                        ((data_ID_i & (data_ID_i - ID_WIDTH'(1))) == '0);
    end else begin : g_binary
        localparam logic [31:0] N_MASTER_U = N_MASTER;
        assign legal  = (32'(data_ID_i) < N_MASTER_U);
        assign target = legal ? (N_MASTER'(1) << data_ID_i) : '0;
    end

    // A slot can take a new response if it is empty or being drained this cycle.
    assign free           = ~slot_vld_p1 | data_r_ready_i;
    // Illegal IDs are always swallowed; legal ones wait for their own slot only.
    assign data_r_ready_o = legal ? |(target & free) : 1'b1;
    assign accept         = data_r_valid_i && data_r_ready_o;
    assign fill           = (accept && legal) ? target : '0;
    assign drop           = accept && !legal;

    // ---- stage p1: per-master slots and error reporting (registered)

    // Slot occupancy: refill wins over drain so a busy master keeps full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_p1 <= '0;
        end else begin
            slot_vld_p1 <= fill | (slot_vld_p1 & ~data_r_ready_i);
        end
    end

    // Slot payload: captured only on fill, otherwise held for the master handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_rdata_p1 <= '0;
            slot_opc_p1   <= '0;
        end else begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (fill[m]) begin
                    slot_rdata_p1[m*DATA_WIDTH +: DATA_WIDTH] <= data_r_rdata_i;
                    slot_opc_p1[m]                            <= data_r_opc_i;
                end
            end
        end
    end

    // Illegal-ID pulse and saturating counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse_p1 <= 1'b0;
            err_cnt_p1   <= '0;
        end else begin
            err_pulse_p1 <= drop;
            if (err_clr_i) begin
                err_cnt_p1 <= '0;
            end else if (drop) begin
                err_cnt_p1 <= sat_inc(err_cnt_p1);
            end
        end
    end

    assign data_r_valid_o = slot_vld_p1;
    assign data_r_rdata_o = slot_rdata_p1;
    assign data_r_opc_o   = slot_opc_p1;
    assign err_pulse_o    = err_pulse_p1;
    assign err_cnt_o      = err_cnt_p1;

endmodule

// File: tb/tb_resp_router_bridge_buf.sv
// Bench for resp_router_bridge_buf: a one-hot instance (4 masters, 2-bit
// error counter) and a binary instance (5 masters, 8-bit error counter).
module tb_resp_router_bridge_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: one-hot IDs, N_MASTER=4, ERR_CNT_WIDTH=2
    logic         a_valid_i, a_ready_o, a_opc_i, a_clr_i, a_pulse_o;
    logic [3:0]   a_id_i, a_valid_o, a_ready_i, a_opc_o;
    logic [31:0]  a_rdata_i;
    logic [127:0] a_rdata_o;
    logic [1:0]   a_cnt_o;

    // Instance B: binary IDs, N_MASTER=5, ERR_CNT_WIDTH=8
    logic         b_valid_i, b_ready_o, b_opc_i, b_clr_i, b_pulse_o;
    logic [2:0]   b_id_i;
    logic [4:0]   b_valid_o, b_ready_i, b_opc_o;
    logic [31:0]  b_rdata_i;
    logic [159:0] b_rdata_o;
    logic [7:0]   b_cnt_o;

    resp_router_bridge_buf #(.N_MASTER(4), .ID_MODE(0), .ID_WIDTH(4),
                             .DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) u_a (
        .clk(clk), .rst(rst),
        .data_r_valid_i(a_valid_i), .data_r_ready_o(a_ready_o),
        .data_ID_i(a_id_i), .data_r_rdata_i(a_rdata_i), .data_r_opc_i(a_opc_i),
        .data_r_valid_o(a_valid_o), .data_r_ready_i(a_ready_i),
        .data_r_rdata_o(a_rdata_o), .data_r_opc_o(a_opc_o),
        .err_clr_i(a_clr_i), .err_pulse_o(a_pulse_o), .err_cnt_o(a_cnt_o));

    resp_router_bridge_buf #(.N_MASTER(5), .ID_MODE(1), .ID_WIDTH(3),
                             .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) u_b (
        .clk(clk), .rst(rst),
        .data_r_valid_i(b_valid_i), .data_r_ready_o(b_ready_o),
        .data_ID_i(b_id_i), .data_r_rdata_i(b_rdata_i), .data_r_opc_i(b_opc_i),
        .data_r_valid_o(b_valid_o), .data_r_ready_i(b_ready_i),
        .data_r_rdata_o(b_rdata_o), .data_r_opc_o(b_opc_o),
        .err_clr_i(b_clr_i), .err_pulse_o(b_pulse_o), .err_cnt_o(b_cnt_o));

    // Reference model: pending response per master, plus error counters.
    bit          pend_a [4];
    logic [31:0] pd_a   [4];
    logic        po_a   [4];
    int          cnt_a;
    bit          pls_a;
    bit          pend_b [5];
    logic [31:0] pd_b   [5];
    logic        po_b   [5];
    int          cnt_b;
    bit          pls_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid_i = 0; a_id_i = '0; a_rdata_i = '0; a_opc_i = 0; a_ready_i = '0; a_clr_i = 0;
        b_valid_i = 0; b_id_i = '0; b_rdata_i = '0; b_opc_i = 0; b_ready_i = '0; b_clr_i = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int m = 0; m < 4; m++) begin pend_a[m] = 0; pd_a[m] = '0; po_a[m] = 0; end
        for (int m = 0; m < 5; m++) begin pend_b[m] = 0; pd_b[m] = '0; po_b[m] = 0; end
        cnt_a = 0; pls_a = 0; cnt_b = 0; pls_b = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        n_cmp++; if ({a_valid_o, a_opc_o, a_pulse_o, a_cnt_o} !== 11'd0) begin n_err++;
            $display("FAIL reset_a_ctrl got=%h want=0", {a_valid_o, a_opc_o, a_pulse_o, a_cnt_o}); end
        n_cmp++; if (a_rdata_o !== 128'd0) begin n_err++;
            $display("FAIL reset_a_rdata got=%h want=0", a_rdata_o); end
        n_cmp++; if ({b_valid_o, b_opc_o, b_pulse_o, b_cnt_o, b_rdata_o} !== '0) begin n_err++;
            $display("FAIL reset_b_outputs got=%h want=0", {b_valid_o, b_opc_o, b_pulse_o, b_cnt_o}); end
        a_valid_i = 1; a_id_i = 4'b0100;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++;
            $display("FAIL reset_a_ready got=%b want=1", a_ready_o); end
        a_valid_i = 0;
    endtask

    task automatic test_basic();
        do_reset();
        a_valid_i = 1; a_id_i = 4'b0100; a_rdata_i = 32'hDEADBEEF; a_opc_i = 0; a_ready_i = 4'hF;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++;
            $display("FAIL basic_ready0 got=%b want=1", a_ready_o); end
        tick();
        a_valid_i = 0;
        #1;
        n_cmp++; if (a_valid_o !== 4'b0100 || a_rdata_o[64 +: 32] !== 32'hDEADBEEF || a_opc_o !== 4'b0000) begin
            n_err++; $display("FAIL basic_deliver got=%b/%h want=0100/deadbeef", a_valid_o, a_rdata_o[64 +: 32]); end
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++;
            $display("FAIL basic_ready1 got=%b want=1", a_ready_o); end
        tick();
        n_cmp++; if (a_valid_o !== 4'b0000 || a_rdata_o[64 +: 32] !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL basic_drain got=%b/%h want=0000/deadbeef", a_valid_o, a_rdata_o[64 +: 32]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        b_valid_i = 1; b_id_i = 3'd3; b_rdata_i = 32'h1111_AAAA; b_opc_i = 1; b_ready_i = 5'b00000;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1) begin n_err++;
            $display("FAIL bp_first_ready got=%b want=1", b_ready_o); end
        tick();
        b_rdata_i = 32'h2222_BBBB; b_opc_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (b_ready_o !== 1'b0 || b_valid_o !== 5'b01000 || b_rdata_o[96 +: 32] !== 32'h1111_AAAA
                         || b_opc_o !== 5'b01000) begin n_err++;
                $display("FAIL bp_stall%0d got=%b/%b/%h want=0/01000/1111aaaa", k, b_ready_o, b_valid_o, b_rdata_o[96 +: 32]); end
            tick();
        end
        b_ready_i = 5'b01000;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1 || b_valid_o !== 5'b01000 || b_rdata_o[96 +: 32] !== 32'h1111_AAAA) begin n_err++;
            $display("FAIL bp_release got=%b/%b/%h want=1/01000/1111aaaa", b_ready_o, b_valid_o, b_rdata_o[96 +: 32]); end
        tick();
        b_valid_i = 0;
        #1;
        n_cmp++; if (b_valid_o !== 5'b01000 || b_rdata_o[96 +: 32] !== 32'h2222_BBBB || b_opc_o !== 5'b00000) begin n_err++;
            $display("FAIL bp_second got=%b/%h want=01000/2222bbbb", b_valid_o, b_rdata_o[96 +: 32]); end
        tick();
        n_cmp++; if (b_valid_o !== 5'b00000) begin n_err++;
            $display("FAIL bp_nodup got=%b want=00000", b_valid_o); end
    endtask

    task automatic test_independence();
        do_reset();
        a_valid_i = 1; a_id_i = 4'b0010; a_rdata_i = 32'h0000_1111; a_ready_i = 4'b0000;
        tick();
        a_id_i = 4'b0001; a_rdata_i = 32'h0000_0F0F;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1 || a_valid_o !== 4'b0010) begin n_err++;
            $display("FAIL indep_accept got=%b/%b want=1/0010", a_ready_o, a_valid_o); end
        tick();
        a_valid_i = 0;
        #1;
        n_cmp++; if (a_valid_o !== 4'b0011 || a_rdata_o[0 +: 32] !== 32'h0000_0F0F
                     || a_rdata_o[32 +: 32] !== 32'h0000_1111) begin n_err++;
            $display("FAIL indep_deliver got=%b/%h/%h want=0011/00000f0f/00001111",
                     a_valid_o, a_rdata_o[0 +: 32], a_rdata_o[32 +: 32]); end
    endtask

    task automatic test_illegal();
        do_reset();
        a_valid_i = 1; a_id_i = 4'b0110; a_ready_i = 4'hF;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++;
            $display("FAIL ill_ready_multi got=%b want=1", a_ready_o); end
        tick();
        a_id_i = 4'b0000;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1 || a_pulse_o !== 1'b1 || a_cnt_o !== 2'd1 || a_valid_o !== 4'b0000) begin n_err++;
            $display("FAIL ill_first got=%b/%b/%0d/%b want=1/1/1/0000", a_ready_o, a_pulse_o, a_cnt_o, a_valid_o); end
        tick();
        a_valid_i = 0;
        #1;
        n_cmp++; if (a_pulse_o !== 1'b1 || a_cnt_o !== 2'd2 || a_valid_o !== 4'b0000) begin n_err++;
            $display("FAIL ill_second got=%b/%0d/%b want=1/2/0000", a_pulse_o, a_cnt_o, a_valid_o); end
        tick();
        n_cmp++; if (a_pulse_o !== 1'b0 || a_cnt_o !== 2'd2) begin n_err++;
            $display("FAIL ill_pulse_end got=%b/%0d want=0/2", a_pulse_o, a_cnt_o); end
        b_valid_i = 1; b_id_i = 3'd7; b_ready_i = 5'h1F;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1) begin n_err++;
            $display("FAIL ill_b_ready got=%b want=1", b_ready_o); end
        tick();
        b_valid_i = 0;
        #1;
        n_cmp++; if (b_pulse_o !== 1'b1 || b_cnt_o !== 8'd1 || b_valid_o !== 5'b00000) begin n_err++;
            $display("FAIL ill_b_drop got=%b/%0d/%b want=1/1/00000", b_pulse_o, b_cnt_o, b_valid_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        a_valid_i = 1; a_id_i = 4'b0011; a_ready_i = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            n_cmp++; if (a_cnt_o !== 2'((k > 3) ? 3 : k)) begin n_err++;
                $display("FAIL sat_cnt%0d got=%0d want=%0d", k, a_cnt_o, (k > 3) ? 3 : k); end
        end
        a_clr_i = 1;
        tick();
        a_clr_i = 0; a_valid_i = 0;
        #1;
        n_cmp++; if (a_cnt_o !== 2'd0 || a_pulse_o !== 1'b1) begin n_err++;
            $display("FAIL sat_clear got=%0d/%b want=0/1", a_cnt_o, a_pulse_o); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        a_valid_i = 1; a_id_i = 4'b0010; a_rdata_i = 32'hAAAA_0001; a_ready_i = 4'b0000;
        tick();
        a_id_i = 4'b1000; a_rdata_i = 32'hAAAA_0003;
        tick();
        a_id_i = 4'b0000;
        tick();
        a_valid_i = 0;
        #1;
        n_cmp++; if (a_valid_o !== 4'b1010 || a_cnt_o !== 2'd1) begin n_err++;
            $display("FAIL mid_setup got=%b/%0d want=1010/1", a_valid_o, a_cnt_o); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_valid_o !== 4'b0000 || a_cnt_o !== 2'd0 || a_pulse_o !== 1'b0) begin n_err++;
            $display("FAIL mid_async got=%b/%0d/%b want=0000/0/0", a_valid_o, a_cnt_o, a_pulse_o); end
        #1 rst = 1'b0;
        a_valid_i = 1; a_id_i = 4'b0010; a_rdata_i = 32'h5A5A_1234; a_ready_i = 4'hF;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++;
            $display("FAIL mid_ready got=%b want=1", a_ready_o); end
        tick();
        a_valid_i = 0;
        #1;
        n_cmp++; if (a_valid_o !== 4'b0010 || a_rdata_o[32 +: 32] !== 32'h5A5A_1234) begin n_err++;
            $display("FAIL mid_after got=%b/%h want=0010/5a5a1234", a_valid_o, a_rdata_o[32 +: 32]); end
    endtask

    task automatic test_random();
        bit          leg_a, leg_b, rdy_a, rdy_b;
        int          ix_a, ix_b;
        logic [3:0]   ev_a, eo_a;
        logic [127:0] ed_a;
        logic [4:0]   ev_b, eo_b;
        logic [159:0] ed_b;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            a_valid_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) a_id_i = 4'b0001 << $urandom_range(0, 3);
            else                          a_id_i = 4'($urandom_range(0, 15));
            a_rdata_i = $urandom; a_opc_i = 1'($urandom_range(0, 1));
            a_ready_i = 4'($urandom_range(0, 15)); a_clr_i = ($urandom_range(0, 19) == 0);
            b_valid_i = ($urandom_range(0, 3) != 0);
            b_id_i    = 3'($urandom_range(0, 7));
            b_rdata_i = $urandom; b_opc_i = 1'($urandom_range(0, 1));
            b_ready_i = 5'($urandom_range(0, 31)); b_clr_i = ($urandom_range(0, 29) == 0);
            #1;
            // Expected observations from the pending-response model.
            leg_a = ($countones(a_id_i) == 1);
            ix_a = 0;
            for (int m = 0; m < 4; m++) if (a_id_i[m]) ix_a = m;
            rdy_a = !leg_a || !pend_a[ix_a] || a_ready_i[ix_a];
            leg_b = (b_id_i < 5);
            ix_b = leg_b ? int'(b_id_i) : 0;
            rdy_b = !leg_b || !pend_b[ix_b] || b_ready_i[ix_b];
            for (int m = 0; m < 4; m++) begin ev_a[m] = pend_a[m]; eo_a[m] = po_a[m]; ed_a[m*32 +: 32] = pd_a[m]; end
            for (int m = 0; m < 5; m++) begin ev_b[m] = pend_b[m]; eo_b[m] = po_b[m]; ed_b[m*32 +: 32] = pd_b[m]; end
            n_cmp++; if (a_ready_o !== rdy_a) begin n_err++;
                $display("FAIL rnd_a_ready c=%0d got=%b want=%b", c, a_ready_o, rdy_a); end
            n_cmp++; if ({a_valid_o, a_opc_o} !== {ev_a, eo_a} || a_rdata_o !== ed_a) begin n_err++;
                $display("FAIL rnd_a_slots c=%0d got=%b/%b want=%b/%b", c, a_valid_o, a_opc_o, ev_a, eo_a); end
            n_cmp++; if (a_pulse_o !== pls_a || a_cnt_o !== 2'(cnt_a)) begin n_err++;
                $display("FAIL rnd_a_err c=%0d got=%b/%0d want=%b/%0d", c, a_pulse_o, a_cnt_o, pls_a, cnt_a); end
            n_cmp++; if (b_ready_o !== rdy_b) begin n_err++;
                $display("FAIL rnd_b_ready c=%0d got=%b want=%b", c, b_ready_o, rdy_b); end
            n_cmp++; if ({b_valid_o, b_opc_o} !== {ev_b, eo_b} || b_rdata_o !== ed_b) begin n_err++;
                $display("FAIL rnd_b_slots c=%0d got=%b/%b want=%b/%b", c, b_valid_o, b_opc_o, ev_b, eo_b); end
            n_cmp++; if (b_pulse_o !== pls_b || b_cnt_o !== 8'(cnt_b)) begin n_err++;
                $display("FAIL rnd_b_err c=%0d got=%b/%0d want=%b/%0d", c, b_pulse_o, b_cnt_o, pls_b, cnt_b); end
            // Advance the model to what the next clock edge should produce.
            for (int m = 0; m < 4; m++) if (pend_a[m] && a_ready_i[m]) pend_a[m] = 0;
            if (a_valid_i && leg_a && rdy_a) begin pend_a[ix_a] = 1; pd_a[ix_a] = a_rdata_i; po_a[ix_a] = a_opc_i; end
            pls_a = a_valid_i && !leg_a;
            if (a_clr_i) cnt_a = 0; else if (pls_a && cnt_a < 3) cnt_a++;
            for (int m = 0; m < 5; m++) if (pend_b[m] && b_ready_i[m]) pend_b[m] = 0;
            if (b_valid_i && leg_b && rdy_b) begin pend_b[ix_b] = 1; pd_b[ix_b] = b_rdata_i; po_b[ix_b] = b_opc_i; end
            pls_b = b_valid_i && !leg_b;
            if (b_clr_i) cnt_b = 0; else if (pls_b && cnt_b < 255) cnt_b++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_basic();
        test_backpressure();
        test_independence();
        test_illegal();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
